// File: rtl/fifo_pkg.sv
// Shared types and helpers for the row-tracking request FIFO.
//   fifo_state_e : occupancy FSM state (EMPTY / MIDDLE / FULL)
//   ptr_width()  : pointer width for a given depth, never below 1 bit
package fifo_pkg;

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    MIDDLE = 2'd1,
    FULL   = 2'd2
  } fifo_state_e;

  function automatic int unsigned ptr_width(input int unsigned depth);
    int unsigned w;
    w = $clog2(depth);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/fifo_ptr_inc.sv
// Modulo-DEPTH pointer incrementer; DEPTH need not be a power of two.
//   i_ptr    : current pointer (0..DEPTH-1)
//   o_next_c : i_ptr + 1, wrapping DEPTH-1 to 0 (combinational)
module fifo_ptr_inc #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic [PTR_W-1:0] i_ptr,
  output logic [PTR_W-1:0] o_next_c
);

  assign o_next_c = (i_ptr == PTR_W'(DEPTH - 1)) ? '0 : i_ptr + PTR_W'(1);

endmodule

// File: rtl/row_tracking_fifo.sv
// Request FIFO for a bank scheduler with occupancy count, fill watermark,
// row-address tracking of the newest push and synchronous flush.
//   clk, rst_n              : clock, async active-low reset
//   flush_i                 : synchronous clear (wins over push/pop)
//   data_i/valid_i/ready_o  : push side
//   data_o/valid_o/ready_i  : pop side (data_o is 0 while empty)
//   count_o, above_wm_o     : occupancy and count_o >= WATERMARK
//   last_row_o/_vld_o       : row field of the newest accepted push
//   row_hit_o               : data_i row matches a still-valid last_row_o
module row_tracking_fifo
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned RA_POS     = 20,
  parameter int unsigned RA_BITS    = 10,
  parameter int unsigned WATERMARK  = DEPTH / 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush_i,
  input  logic [DATA_WIDTH-1:0]        data_i,
  input  logic                         valid_i,
  output logic                         ready_o,
  output logic [DATA_WIDTH-1:0]        data_o,
  output logic                         valid_o,
  input  logic                         ready_i,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         above_wm_o,
  output logic [RA_BITS-1:0]           last_row_o,
  output logic                         last_row_vld_o,
  output logic                         row_hit_o
);

  localparam int unsigned PTR_W = ptr_width(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  fifo_state_e             r_state, w_state_nxt;
  logic [PTR_W-1:0]        r_wr_ptr, w_wr_ptr_nxt, w_wr_ptr_inc;
  logic [PTR_W-1:0]        r_rd_ptr, w_rd_ptr_nxt, w_rd_ptr_inc;
  logic [CNT_W-1:0]        r_count, w_count_nxt;
  logic [RA_BITS-1:0]      r_last_row, w_last_row_nxt;
  logic                    r_last_row_vld, w_last_row_vld_nxt;
  logic                    w_wr_en;
  logic [RA_BITS-1:0]      w_row_in;
  logic [DATA_WIDTH-1:0]   r_mem [DEPTH];

  assign w_row_in = data_i[RA_POS +: RA_BITS];

  fifo_ptr_inc #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_wr_inc (
    .i_ptr    (r_wr_ptr),
    .o_next_c (w_wr_ptr_inc)
  );

  fifo_ptr_inc #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_rd_inc (
    .i_ptr    (r_rd_ptr),
    .o_next_c (w_rd_ptr_inc)
  );

  // State, pointer, count and row-tracker registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= EMPTY;
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_count        <= '0;
      r_last_row     <= '0;
      r_last_row_vld <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_wr_ptr       <= w_wr_ptr_nxt;
      r_rd_ptr       <= w_rd_ptr_nxt;
      r_count        <= w_count_nxt;
      r_last_row     <= w_last_row_nxt;
      r_last_row_vld <= w_last_row_vld_nxt;
    end
  end

  // Next-state logic; push is only honoured outside FULL, pop only outside EMPTY
  always_comb begin
    w_state_nxt        = r_state;
    w_wr_ptr_nxt       = r_wr_ptr;
    w_rd_ptr_nxt       = r_rd_ptr;
    w_count_nxt        = r_count;
    w_last_row_nxt     = r_last_row;
    w_last_row_vld_nxt = r_last_row_vld;
    w_wr_en            = 1'b0;

    if (flush_i) begin
      w_state_nxt        = EMPTY;
      w_wr_ptr_nxt       = '0;
      w_rd_ptr_nxt       = '0;
      w_count_nxt        = '0;
      w_last_row_vld_nxt = 1'b0;
    end else begin
      case (r_state)
        EMPTY: begin
          if (valid_i) begin
            w_wr_en            = 1'b1;
            w_wr_ptr_nxt       = w_wr_ptr_inc;
            w_count_nxt        = CNT_W'(1);
            w_last_row_nxt     = w_row_in;
            w_last_row_vld_nxt = 1'b1;
            // DEPTH >= 2, so a single entry can never be FULL
            w_state_nxt        = MIDDLE;
          end
        end
        MIDDLE: begin
          if (valid_i) begin
            w_wr_en            = 1'b1;
            w_wr_ptr_nxt       = w_wr_ptr_inc;
            w_last_row_nxt     = w_row_in;
            w_last_row_vld_nxt = 1'b1;
          end
          if (ready_i) begin
            w_rd_ptr_nxt = w_rd_ptr_inc;
          end
          if (valid_i && !ready_i) begin
            w_count_nxt = r_count + CNT_W'(1);
            if (r_count == CNT_W'(DEPTH - 1)) begin
              w_state_nxt = FULL;
            end
          end else if (!valid_i && ready_i) begin
            w_count_nxt = r_count - CNT_W'(1);
            if (r_count == CNT_W'(1)) begin
              w_state_nxt        = EMPTY;
              w_last_row_vld_nxt = 1'b0;
            end
          end
        end
        FULL: begin
          if (ready_i) begin
            w_rd_ptr_nxt = w_rd_ptr_inc;
            w_count_nxt  = r_count - CNT_W'(1);
            w_state_nxt  = MIDDLE;
          end
        end
        default: begin
          w_state_nxt        = EMPTY;
          w_wr_ptr_nxt       = '0;
          w_rd_ptr_nxt       = '0;
          w_count_nxt        = '0;
          w_last_row_vld_nxt = 1'b0;
        end
      endcase
    end
  end

  // Storage array, intentionally without reset
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr] <= data_i;
    end
  end

  assign ready_o        = (r_state != FULL);
  assign valid_o        = (r_state != EMPTY);
  assign data_o         = (r_state != EMPTY) ? r_mem[r_rd_ptr] : '0;
  assign count_o        = r_count;
  assign above_wm_o     = (r_count >= CNT_W'(WATERMARK));
  assign last_row_o     = r_last_row;
  assign last_row_vld_o = r_last_row_vld;
  assign row_hit_o      = r_last_row_vld && (w_row_in == r_last_row);

endmodule

// File: tb/tb_row_tracking_fifo.sv
// Randomised plus directed bench for row_tracking_fifo. Two instances share
// the stimulus: default DEPTH=4 and an odd DEPTH=3/WATERMARK=2 variant.
// Each has a queue-based reference model.
module tb_row_tracking_fifo;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush_i;
  logic [31:0] data_i;
  logic        valid_i;
  logic        ready_i;

  logic        rdy4, vld4, awm4, lrv4, hit4;
  logic [31:0] dat4;
  logic [2:0]  cnt4;
  logic [9:0]  lr4;

  logic        rdy3, vld3, awm3, lrv3, hit3;
  logic [31:0] dat3;
  logic [1:0]  cnt3;
  logic [9:0]  lr3;

  int n_pass  = 0;
  int n_total = 0;

  logic [31:0] q4[$];
  logic [31:0] q3[$];
  logic [9:0]  m_lr4, m_lr3;
  logic        m_lv4, m_lv3;
  int          max_cnt4;

  always #5 clk = ~clk;

  row_tracking_fifo u_dut4 (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
    .data_i(data_i), .valid_i(valid_i), .ready_o(rdy4),
    .data_o(dat4), .valid_o(vld4), .ready_i(ready_i),
    .count_o(cnt4), .above_wm_o(awm4),
    .last_row_o(lr4), .last_row_vld_o(lrv4), .row_hit_o(hit4)
  );

  row_tracking_fifo #(.DEPTH(3), .WATERMARK(2)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
    .data_i(data_i), .valid_i(valid_i), .ready_o(rdy3),
    .data_o(dat3), .valid_o(vld3), .ready_i(ready_i),
    .count_o(cnt3), .above_wm_o(awm3),
    .last_row_o(lr3), .last_row_vld_o(lrv3), .row_hit_o(hit3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
  endtask

  task automatic check_inst(input string n, input int depth, input int wm,
                            input logic rdy, input logic vld, input logic [31:0] dat,
                            input logic [31:0] cnt, input logic awm, input logic [9:0] lr,
                            input logic lrv, input logic hit,
                            input int size, input logic [31:0] head,
                            input logic [9:0] mlr, input logic mlv);
    logic [9:0] row_in;
    row_in = data_i[29:20];
    check({n, ".ready"},    32'(rdy), 32'(size < depth));
    check({n, ".valid"},    32'(vld), 32'(size > 0));
    check({n, ".data"},     dat, (size > 0) ? head : 32'h0);
    check({n, ".count"},    cnt, 32'(size));
    check({n, ".above_wm"}, 32'(awm), 32'(size >= wm));
    check({n, ".last_row"}, 32'(lr), 32'(mlr));
    check({n, ".row_vld"},  32'(lrv), 32'(mlv));
    check({n, ".row_hit"},  32'(hit), 32'(mlv && (row_in == mlr)));
  endtask

  task automatic check_all();
    check_inst("d4", 4, 2, rdy4, vld4, dat4, 32'(cnt4), awm4, lr4, lrv4, hit4,
               q4.size(), (q4.size() > 0) ? q4[0] : 32'h0, m_lr4, m_lv4);
    check_inst("d3", 3, 2, rdy3, vld3, dat3, 32'(cnt3), awm3, lr3, lrv3, hit3,
               q3.size(), (q3.size() > 0) ? q3[0] : 32'h0, m_lr3, m_lv3);
  endtask

  task automatic model_reset();
    q4.delete(); q3.delete();
    m_lr4 = '0; m_lr3 = '0; m_lv4 = 1'b0; m_lv3 = 1'b0;
  endtask

  // Reference behaviour for one clock edge, applied to both instances
  task automatic model_edge();
    bit push_ok, pop_ok;
    if (flush_i) begin
      q4.delete(); q3.delete(); m_lv4 = 1'b0; m_lv3 = 1'b0;
      return;
    end
    push_ok = valid_i && (q4.size() < 4);
    pop_ok  = ready_i && (q4.size() > 0);
    if (pop_ok) void'(q4.pop_front());
    if (push_ok) begin q4.push_back(data_i); m_lr4 = data_i[29:20]; m_lv4 = 1'b1; end
    else if (pop_ok && q4.size() == 0) m_lv4 = 1'b0;
    push_ok = valid_i && (q3.size() < 3);
    pop_ok  = ready_i && (q3.size() > 0);
    if (pop_ok) void'(q3.pop_front());
    if (push_ok) begin q3.push_back(data_i); m_lr3 = data_i[29:20]; m_lv3 = 1'b1; end
    else if (pop_ok && q3.size() == 0) m_lv3 = 1'b0;
    if (q4.size() > max_cnt4) max_cnt4 = q4.size();
  endtask

  // One cycle: drive, check pre-edge outputs, advance model and clock
  task automatic cycle(input logic v, input logic r, input logic f, input logic [31:0] d);
    valid_i = v; ready_i = r; flush_i = f; data_i = d;
    #1;
    check_all();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    w[31:30] = 2'b00;
    w[29:20] = 10'($urandom_range(0, 3));
    return w;
  endfunction

  initial begin
    rst_n = 1'b0; flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b0; data_i = '0;
    max_cnt4 = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Fill and drain
    for (int i = 1; i <= 4; i++) cycle(1'b1, 1'b0, 1'b0, 32'((i << 20) | i));
    check("fill.ready_low", 32'(rdy4), 32'd0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b0, 32'h0);
    check("drain.valid_low", 32'(vld4), 32'd0);

    // Wrap-around with occupancy held at 1..3
    max_cnt4 = 0;
    cycle(1'b1, 1'b0, 1'b0, 32'h0011_0011);
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b1, 1'b0, 32'(32'h0020_0000 + i));
    cycle(1'b1, 1'b0, 1'b0, 32'h0030_0077);
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b1, 1'b0, 32'(32'h0040_0000 + i));
    check("wrap.max_cnt", 32'(max_cnt4 <= 3), 32'd1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 32'h0);

    // Row tracking
    cycle(1'b1, 1'b0, 1'b0, 32'h0050_0000);
    cycle(1'b0, 1'b0, 1'b0, 32'h0050_1234);
    check("row.hit5", 32'(hit4), 32'd1);
    cycle(1'b0, 1'b0, 1'b0, 32'h0060_1234);
    check("row.miss6", 32'(hit4), 32'd0);
    cycle(1'b0, 1'b1, 1'b0, 32'h0050_1234);
    cycle(1'b0, 1'b0, 1'b0, 32'h0050_1234);
    check("row.empty_nohit", 32'(hit4), 32'd0);

    // Full with push+pop, then empty with push+pop
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0, rand_word());
    cycle(1'b1, 1'b1, 1'b0, 32'h0077_7777);
    check("full_pp.count3", 32'(cnt4), 32'd3);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 1'b0, 32'h0088_8888);
    check("empty_pp.data", dat4, 32'h0088_8888);
    cycle(1'b0, 1'b1, 1'b0, 32'h0);

    // Flush at count 3 together with a push
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, rand_word());
    cycle(1'b1, 1'b0, 1'b1, 32'h0099_9999);
    check("flush.count0", 32'(cnt4), 32'd0);
    cycle(1'b0, 1'b0, 1'b0, 32'h0);

    // Randomised traffic with occasional flush and one async reset mid-burst
    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        valid_i = 1'b1; ready_i = 1'b0; flush_i = 1'b0; data_i = rand_word();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        valid_i = 1'b0;
        check_all();
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
      end
      cycle(1'($urandom_range(0, 99) < 60), 1'($urandom_range(0, 99) < 50),
            1'($urandom_range(0, 99) < 3), rand_word());
    end
    cycle(1'b0, 1'b0, 1'b0, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
